// File: rtl/mem_resp_pkg.sv
// Shared types and lane helpers for the memory responder.
// Optional fault checking in the top is enabled by MEMRESP_ERR_EN.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      COMMIT,
      RESP
   } state_t;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   function automatic logic [3:0] lane_mask(
      input logic [1:0] size,
      input logic [1:0] lane
   );
      logic [3:0] m;
      m = 4'b1111;
      unique case (size)
         SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: m = 4'b0001 << lane;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Right-justified store data is moved onto its lanes, then masked in.
   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] wdata,
      input logic [3:0]  mask,
      input logic [1:0]  lane
   );
      logic [31:0] d;
      logic [31:0] r;
      if (mask == 4'b1111)
         d = wdata;
      else if (mask == 4'b0011 || mask == 4'b1100)
         d = wdata << {lane[1], 4'b0000};
      else
         d = wdata << {lane, 3'b000};
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = mask[i] ? d[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/mem_resp_bank.sv
// Word-organised storage: byte-enable synchronous write,
// combinational read, contents never reset.
module mem_resp_bank #(
   parameter int DEPTH_WORDS = 256,
   parameter int IW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [IW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory responder with programmable wait states.
// Define MEMRESP_ERR_EN to flag misaligned/reserved/out-of-range accesses.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int IW = $clog2(DEPTH_WORDS);

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic [ADDR_W-1:0] a_q;
   logic              wr_q;
   logic [1:0]        sz_q;
   logic [31:0]       wd_q;
   logic [3:0]        mask;
   logic [31:0]       rd;
   logic [31:0]       merged;
   logic              err;
   logic              we;

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign resp_valid = (state == RESP);

   assign mask   = lane_mask(sz_q, a_q[1:0]);
   assign merged = merge(rd, wd_q, mask, a_q[1:0]);
   assign we     = (state == COMMIT) && wr_q && !err;

`ifdef MEMRESP_ERR_EN
   logic [ADDR_W-3:0] hi;
   logic              mis;
   logic              oob;
   assign hi  = a_q[ADDR_W-1:2];
   assign oob = (hi >> IW) != '0;
   assign mis = ((sz_q == SZ_WORD) && (a_q[1:0] != 2'b00))
              || ((sz_q == SZ_HALF) && a_q[0]);
   assign err = mis || oob || (sz_q == SZ_RSVD);
`else
   logic unused_hi;
   assign unused_hi = ^a_q[ADDR_W-1:IW+2];
   assign err       = 1'b0;
`endif

   mem_resp_bank #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_bank (
      .clock(clock),
      .we   (we),
      .be   (mask),
      .idx  (a_q[IW+1:2]),
      .wdata(merged),
      .rdata(rd)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  state_n = COMMIT;
               end else begin
                  state_n = WAIT;
                  cnt_n   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_n = COMMIT;
            else             cnt_n   = cnt - 4'd1;
         end
         COMMIT: state_n = RESP;
         RESP:   if (resp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_q  <= '0;
         wr_q <= 1'b0;
         sz_q <= SZ_WORD;
         wd_q <= '0;
      end else if (state == IDLE && req_valid) begin
         a_q  <= req_addr;
         wr_q <= req_wr;
         sz_q <= req_size;
         wd_q <= req_wdata;
      end
   end

   // Response carries the post-commit view of the word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (state == COMMIT) begin
         resp_err <= err;
         if (err)       resp_rdata <= '0;
         else if (wr_q) resp_rdata <= merged;
         else           resp_rdata <= rd;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 and LATENCY=0 instances.
// Expectations follow MEMRESP_ERR_EN when the bench is built with it.
module tb_mem_responder;

   logic        clk;
   logic        rst_n;

   logic        a_valid, a_ready, a_wr;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [1:0]  a_size;
   logic        a_rvalid, a_rready, a_err, a_busy;

   logic        b_valid, b_ready, b_wr;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [1:0]  b_size;
   logic        b_rvalid, b_rready, b_err, b_busy;

   int checks = 0;
   int fails  = 0;

   mem_responder #(.LATENCY(2)) u2 (
      .clock     (clk),
      .reset     (rst_n),
      .req_valid (a_valid),
      .req_ready (a_ready),
      .req_addr  (a_addr),
      .req_wr    (a_wr),
      .req_size  (a_size),
      .req_wdata (a_wdata),
      .resp_valid(a_rvalid),
      .resp_ready(a_rready),
      .resp_rdata(a_rdata),
      .resp_err  (a_err),
      .busy      (a_busy)
   );

   mem_responder #(.LATENCY(0)) u0 (
      .clock     (clk),
      .reset     (rst_n),
      .req_valid (b_valid),
      .req_ready (b_ready),
      .req_addr  (b_addr),
      .req_wr    (b_wr),
      .req_size  (b_size),
      .req_wdata (b_wdata),
      .resp_valid(b_rvalid),
      .resp_ready(b_rready),
      .resp_rdata(b_rdata),
      .resp_err  (b_err),
      .busy      (b_busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One transfer on the LATENCY=2 port; hold>0 stalls resp_ready.
   task automatic txn(
      input string       tag,
      input logic [31:0] addr,
      input logic        wr,
      input logic [1:0]  sz,
      input logic [31:0] wd,
      input logic [31:0] exp,
      input logic        exp_err,
      input int          hold
   );
      int n;
      logic [31:0] r0;
      logic ok;
      @(negedge clk);
      a_valid = 1; a_addr = addr; a_wr = wr;
      a_size = sz; a_wdata = wd;
      chk({tag, "_rdy"}, 32'(a_ready), 32'd1);
      @(posedge clk);
      #1;
      a_valid = 0; a_addr = 32'hFFFF_FFFC;
      a_wr = ~wr; a_wdata = ~wd; a_size = 2'b10;
      n = 1;
      while (!a_rvalid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd4);
      chk({tag, "_data"}, a_rdata, exp);
      chk({tag, "_err"}, 32'(a_err), 32'(exp_err));
      if (hold > 0) begin
         r0 = a_rdata;
         ok = 1;
         a_valid = 1; a_wr = 1; a_addr = 32'h10;
         a_size = 2'b00; a_wdata = 32'h0;
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (!a_rvalid || a_rdata !== r0 || a_ready) ok = 0;
         end
         chk({tag, "_hold"}, 32'(ok), 32'd1);
         a_valid = 0;
      end
      a_rready = 1;
      @(posedge clk);
      #1;
      a_rready = 0;
      chk({tag, "_idle"}, {30'd0, a_busy, a_ready}, 32'd1);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vb [8];

   initial begin
      int acc, rsp, cyc, last;
      logic both;
      rst_n = 0;
      a_valid = 0; a_addr = 0; a_wr = 0; a_size = 0;
      a_wdata = 0; a_rready = 0;
      b_valid = 0; b_addr = 0; b_wr = 0; b_size = 0;
      b_wdata = 0; b_rready = 0;
      repeat (2) @(negedge clk);
      chk("rst_out", {a_rdata}, 32'd0);
      chk("rst_flags",
          {27'd0, a_ready, a_rvalid, a_err, a_busy, b_ready},
          32'b10001);
      rst_n = 1;

      txn("st_w", 32'h10, 1, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
      txn("ld_w", 32'h10, 0, 2'b00, 32'h0, 32'hDEADBEEF, 0, 0);
      txn("st_b", 32'h11, 1, 2'b10, 32'h000000AA, 32'hDEADAAEF, 0, 0);
      txn("ld_b", 32'h10, 0, 2'b00, 32'h0, 32'hDEADAAEF, 0, 0);
      txn("st_h", 32'h12, 1, 2'b01, 32'hFFFF1234, 32'h1234AAEF, 0, 0);
      txn("ld_hold", 32'h10, 0, 2'b00, 32'h0, 32'h1234AAEF, 0, 10);
      repeat (3) @(posedge clk);
      #1;
      chk("no_queue", 32'(a_rvalid), 32'd0);
      txn("ld_after", 32'h10, 0, 2'b00, 32'h0, 32'h1234AAEF, 0, 0);

      // Reset while the store is still waiting.
      txn("st_20", 32'h20, 1, 2'b00, 32'h01020304, 32'h01020304, 0, 0);
      @(negedge clk);
      a_valid = 1; a_addr = 32'h20; a_wr = 1;
      a_size = 2'b00; a_wdata = 32'h55555555;
      @(posedge clk);
      #1;
      a_valid = 0;
      @(posedge clk);
      #1;
      chk("wait_busy", 32'(a_busy), 32'd1);
      rst_n = 0;
      #1;
      chk("rst_wait_data", a_rdata, 32'd0);
      chk("rst_wait_flags",
          {28'd0, a_ready, a_rvalid, a_err, a_busy}, 32'b1000);
      @(negedge clk);
      rst_n = 1;
      txn("ld_20", 32'h20, 0, 2'b00, 32'h0, 32'h01020304, 0, 0);

      txn("st_0", 32'h0, 1, 2'b00, 32'h11111111, 32'h11111111, 0, 0);
`ifdef MEMRESP_ERR_EN
      txn("ld_mis", 32'h13, 0, 2'b00, 32'h0, 32'h0, 1, 0);
      txn("st_oob", 32'h400, 1, 2'b00, 32'hCAFEF00D, 32'h0, 1, 0);
      txn("ld_0", 32'h0, 0, 2'b00, 32'h0, 32'h11111111, 0, 0);
`else
      txn("ld_mis", 32'h13, 0, 2'b00, 32'h0, 32'h1234AAEF, 0, 0);
      txn("st_oob", 32'h400, 1, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
      txn("ld_0", 32'h0, 0, 2'b00, 32'h0, 32'hCAFEF00D, 0, 0);
`endif

      // Back-to-back stream on the zero-latency port.
      for (int k = 0; k < 4; k++) begin
         vb[k].wr = 1;
         vb[k].addr = 32'(k * 4);
         vb[k].wd = 32'hA5000000 + 32'(k * 3);
         vb[k].exp = vb[k].wd;
         vb[k+4].wr = 0;
         vb[k+4].addr = 32'(k * 4);
         vb[k+4].wd = 32'h0;
         vb[k+4].exp = vb[k].wd;
      end
      b_rready = 1;
      acc = 0; rsp = 0; cyc = 0; last = 0; both = 0;
      while (rsp < 8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (b_ready && b_rvalid) both = 1;
         if (b_rvalid) begin
            chk($sformatf("b2b_data%0d", rsp), b_rdata, vb[rsp].exp);
            if (rsp > 0)
               chk($sformatf("b2b_gap%0d", rsp), 32'(cyc - last), 32'd3);
            last = cyc;
            rsp++;
         end
         if (b_ready && acc < 8) begin
            b_valid = 1; b_wr = vb[acc].wr; b_addr = vb[acc].addr;
            b_size = 2'b00; b_wdata = vb[acc].wd;
            acc++;
         end else begin
            b_valid = 0;
         end
      end
      chk("b2b_count", 32'(rsp), 32'd8);
      chk("b2b_overlap", 32'(both), 32'd0);
      repeat (4) begin
         @(negedge clk);
         if (b_rvalid) rsp++;
      end
      chk("b2b_nodup", 32'(rsp), 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
